// File: rtl/run_pkg.sv
// Shared types and constants for the JPEG-LS run-mode coder (decoder and encoder side).
package run_pkg;

    typedef enum logic [1:0] {IDLE, UNARY, REM, DONE} state_t;

    localparam int IDX_W = 5;
    localparam int J_W   = 4;

    localparam logic [J_W-1:0] J_TABLE [32] = '{
        4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
        4'd2,  4'd2,  4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
        4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    // Run granule 2^J[idx]; J tops out at 15 so 16 bits always suffice.
    function automatic logic [15:0] rg_of(input logic [IDX_W-1:0] idx);
        return 16'(1) << J_TABLE[idx];
    endfunction

endpackage

// File: rtl/run_j_rom.sv
// Combinational RUNindex -> J lookup, shared by the run encoder and decoder.
module run_j_rom
    import run_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [J_W-1:0]   j
);

    assign j = J_TABLE[idx];

endmodule

// File: rtl/run_dec.sv
// JPEG-LS run-mode decoder: rebuilds run length from the serial run code, tracks RUNindex.
// Optional remainder-overflow check enabled by defining RUN_DEC_ERR_CHK_EN.
module run_dec
    import run_pkg::*;
#(
    parameter int RUN_W   = 10,
    parameter int IDX_MAX = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    output logic             start_ready,
    input  logic [RUN_W-1:0] remaining,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             run_valid,
    input  logic             run_ready,
    output logic [RUN_W-1:0] run_len,
    output logic             run_intr,
    output logic [3:0]       j_out,
    output logic [4:0]       run_index,
    output logic             err
);

    // Common width for comparing 16-bit granules/remainders against RUN_W counts.
    localparam int CW = (RUN_W > 16) ? RUN_W : 16;

    state_t           state_q, state_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [RUN_W-1:0] acc_q, acc_nxt;
    logic [RUN_W-1:0] left_q, left_nxt;
    logic [14:0]      rem_q, rem_nxt;
    logic [J_W-1:0]   bitcnt_q, bitcnt_nxt;
    logic [J_W-1:0]   j_q, j_nxt;
    logic             intr_q, intr_nxt;
`ifdef RUN_DEC_ERR_CHK_EN
    logic             err_q, err_nxt;
`endif

    logic [J_W-1:0]   j_cur;
    logic [15:0]      rg;
    logic [15:0]      rem_shift;
    logic [IDX_W-1:0] idx_inc, idx_dec;
    logic             take;

    run_j_rom u_j_rom (
        .idx (idx_q),
        .j   (j_cur)
    );

    assign rg        = rg_of(idx_q);
    assign rem_shift = {rem_q, bit_in};
    assign idx_inc   = (idx_q >= IDX_W'(IDX_MAX)) ? idx_q : idx_q + 1'b1;
    assign idx_dec   = (idx_q != '0) ? idx_q - 1'b1 : idx_q;
    assign take      = bit_valid & bit_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            left_q   <= '0;
            rem_q    <= '0;
            bitcnt_q <= '0;
            j_q      <= '0;
            intr_q   <= 1'b0;
`ifdef RUN_DEC_ERR_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_nxt;
            acc_q    <= acc_nxt;
            left_q   <= left_nxt;
            rem_q    <= rem_nxt;
            bitcnt_q <= bitcnt_nxt;
            j_q      <= j_nxt;
            intr_q   <= intr_nxt;
`ifdef RUN_DEC_ERR_CHK_EN
            err_q    <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state_q;
        idx_nxt    = idx_q;
        acc_nxt    = acc_q;
        left_nxt   = left_q;
        rem_nxt    = rem_q;
        bitcnt_nxt = bitcnt_q;
        j_nxt      = j_q;
        intr_nxt   = intr_q;
`ifdef RUN_DEC_ERR_CHK_EN
        err_nxt    = err_q;
`endif
        if (clear) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
`ifdef RUN_DEC_ERR_CHK_EN
            err_nxt   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_nxt   = '0;
                        left_nxt  = remaining;
                        intr_nxt  = 1'b0;
                        j_nxt     = '0;
                        state_nxt = (remaining == '0) ? DONE : UNARY;
                    end
                end
                UNARY: begin
                    if (take) begin
                        if (bit_in) begin
                            if (CW'(rg) <= CW'(left_q)) begin
                                acc_nxt  = acc_q + RUN_W'(rg);
                                left_nxt = left_q - RUN_W'(rg);
                                idx_nxt  = idx_inc;
                                if (left_q == RUN_W'(rg))
                                    state_nxt = DONE;
                            end else begin
                                // Partial granule: the run reaches end-of-line.
                                acc_nxt   = acc_q + left_q;
                                left_nxt  = '0;
                                state_nxt = DONE;
                            end
                        end else begin
                            j_nxt = j_cur;
                            if (j_cur == '0) begin
                                intr_nxt  = 1'b1;
                                idx_nxt   = idx_dec;
                                state_nxt = DONE;
                            end else begin
                                bitcnt_nxt = j_cur;
                                rem_nxt    = '0;
                                state_nxt  = REM;
                            end
                        end
                    end
                end
                REM: begin
                    if (take) begin
                        rem_nxt    = rem_shift[14:0];
                        bitcnt_nxt = bitcnt_q - 1'b1;
                        if (bitcnt_q == J_W'(1)) begin
                            intr_nxt  = 1'b1;
                            idx_nxt   = idx_dec;
                            state_nxt = DONE;
`ifdef RUN_DEC_ERR_CHK_EN
                            if (CW'(rem_shift) >= CW'(left_q)) begin
                                err_nxt = 1'b1;
                                acc_nxt = acc_q + left_q - 1'b1;
                            end else begin
                                acc_nxt = acc_q + RUN_W'(rem_shift);
                            end
`else
                            acc_nxt = acc_q + RUN_W'(rem_shift);
`endif
                        end
                    end
                end
                DONE: begin
                    if (run_ready) begin
                        state_nxt = IDLE;
`ifdef RUN_DEC_ERR_CHK_EN
                        err_nxt   = 1'b0;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        bit_ready   = ((state_q == UNARY) || (state_q == REM)) && !clear;
        run_valid   = (state_q == DONE);
        run_len     = (state_q == DONE) ? acc_q : '0;
        run_intr    = (state_q == DONE) && intr_q;
        j_out       = ((state_q == DONE) && intr_q) ? j_q : '0;
        run_index   = idx_q;
`ifdef RUN_DEC_ERR_CHK_EN
        err         = err_q;
`else
        err         = 1'b0;
`endif
    end

endmodule

// File: tb/tb_run_dec.sv
// Randomized self-checking bench for run_dec against a plain-arithmetic run-mode model.
module tb_run_dec;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       start_ready;
    logic [9:0] remaining = '0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       run_valid;
    logic       run_ready = 1'b0;
    logic [9:0] run_len;
    logic       run_intr;
    logic [3:0] j_out;
    logic [4:0] run_index;
    logic       err;

    run_dec dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .start       (start),
        .start_ready (start_ready),
        .remaining   (remaining),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .run_valid   (run_valid),
        .run_ready   (run_ready),
        .run_len     (run_len),
        .run_intr    (run_intr),
        .j_out       (j_out),
        .run_index   (run_index),
        .err         (err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc = 0;
    int ptr = 0;
    int last_take = -1;
    int m_idx = 0;
    bit chk_en = 1'b0;
    int e_len, e_intr, e_j, e_idx, e_n, e_err;

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        tot_cnt++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // J from the table shape: groups of 4, then pairs, then singles.
    function automatic int j_of(input int idx);
        if (idx < 16) return idx / 4;
        if (idx < 24) return 4 + (idx - 16) / 2;
        return idx - 16;
    endfunction

    function automatic void model_run(input int idx0, input int rem, input logic [63:0] b,
                                      output int len, output int intr, output int j,
                                      output int idx, output int n, output int e);
        int acc, left, g, r, jj;
        bit done;
        acc = 0; left = rem; n = 0; intr = 0; j = 0; e = 0; idx = idx0; done = (rem == 0);
        while (!done && n < 64) begin
            if (b[n]) begin
                n++;
                g = 1 << j_of(idx);
                if (g <= left) begin
                    acc += g; left -= g;
                    if (idx < 31) idx++;
                    if (left == 0) done = 1;
                end else begin
                    acc += left; left = 0; done = 1;
                end
            end else begin
                n++;
                jj = j_of(idx);
                j = jj;
                r = 0;
                for (int k = 0; k < jj; k++) begin
                    r = r * 2 + ((n < 64) ? int'(b[n]) : 0);
                    n++;
                end
`ifdef RUN_DEC_ERR_CHK_EN
                if (r >= left) begin acc += left - 1; e = 1; end
                else acc += r;
`else
                acc += r;
`endif
                acc = acc % 1024;
                intr = 1;
                if (idx > 0) idx--;
                done = 1;
            end
        end
        len = acc % 1024;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && bit_valid && bit_ready) begin
            ptr <= ptr + 1;
            last_take <= cyc + 1;
        end
    end

    // Result outputs must equal the model for every cycle the result is presented.
    always @(negedge clk) begin
        if (chk_en && run_valid) begin
            chk("run_len", int'(run_len), e_len);
            chk("run_intr", int'(run_intr), e_intr);
            chk("j_out", int'(j_out), e_j);
            chk("run_index", int'(run_index), e_idx);
            chk("err", int'(err), e_err);
            chk("bit_ready_done", int'(bit_ready), 0);
            chk("start_ready_done", int'(start_ready), 0);
        end
    end

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_idx = 0;
    endtask

    task automatic run_one(input int rem, input logic [63:0] b, input int hold);
        int t, base;
        model_run(m_idx, rem, b, e_len, e_intr, e_j, e_idx, e_n, e_err);
        base = ptr;
        chk_en = 1'b1;
        start = 1'b1;
        remaining = 10'(rem);
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!run_valid && t < 300) begin
            bit_valid = ($urandom % 4) != 0;
            bit_in = b[(ptr - base) % 64];
            @(posedge clk); #1;
            t++;
        end
        if (!run_valid) fail_now("run_timeout");
        else if (e_n > 0) chk("latency", last_take, cyc);
        // Keep offering a bit while the result is held; none may be taken.
        bit_valid = 1'b1;
        bit_in = b[(ptr - base) % 64];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        run_ready = 1'b1;
        @(posedge clk); #1;
        run_ready = 1'b0;
        bit_valid = 1'b0;
        chk_en = 1'b0;
        chk("consumed", ptr - base, e_n);
        chk("start_ready_after", int'(start_ready), 1);
        chk("run_valid_after", int'(run_valid), 0);
        chk("index_after", int'(run_index), e_idx);
        m_idx = e_idx;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] b;
        int t;
        #12;
        chk("rst_start_ready", int'(start_ready), 1);
        chk("rst_bit_ready", int'(bit_ready), 0);
        chk("rst_run_valid", int'(run_valid), 0);
        chk("rst_run_len", int'(run_len), 0);
        chk("rst_run_intr", int'(run_intr), 0);
        chk("rst_j_out", int'(j_out), 0);
        chk("rst_run_index", int'(run_index), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Directed: bits 1,1,1,1,0,1 with remaining 10, result held 3 cycles.
        do_clear();
        run_one(10, 64'b101111, 3);
        chk("t1_len", e_len, 5); chk("t1_intr", e_intr, 1);
        chk("t1_j", e_j, 1); chk("t1_idx", e_idx, 3); chk("t1_n", e_n, 6);

        // End-of-line exactly on granule boundaries; 4th offered bit ignored.
        do_clear();
        run_one(3, 64'hF, 1);
        chk("t2_len", e_len, 3); chk("t2_intr", e_intr, 0);
        chk("t2_idx", e_idx, 3); chk("t2_n", e_n, 3);

        // Reach RUNindex 4, then a partial granule (rg=2 > left=1).
        do_clear();
        run_one(4, 64'hF, 0);
        chk("t3a_idx", e_idx, 4);
        run_one(1, 64'h1, 2);
        chk("t3_len", e_len, 1); chk("t3_intr", e_intr, 0); chk("t3_idx", e_idx, 4);

        // Immediate interruption with J=0.
        do_clear();
        run_one(5, 64'h0, 0);
        chk("t4_len", e_len, 0); chk("t4_intr", e_intr, 1);
        chk("t4_j", e_j, 0); chk("t4_idx", e_idx, 0); chk("t4_n", e_n, 1);

        // remaining=0 finishes without consuming bits.
        run_one(0, 64'hFFFF, 1);
        chk("t5_n", e_n, 0); chk("t5_len", e_len, 0);

        // Remainder of 3 with left=2 at J=2.
        do_clear();
        run_one(14, 64'h6FF, 1);
`ifdef RUN_DEC_ERR_CHK_EN
        chk("t6_len", e_len, 13); chk("t6_err", e_err, 1);
`else
        chk("t6_len", e_len, 15); chk("t6_err", e_err, 0);
`endif
        chk("t6_idx", e_idx, 7); chk("t6_j", e_j, 2);

        // Reset in REM after the first of two remainder bits.
        do_clear();
        b = 64'h2FF;
        start = 1'b1; remaining = 10'd100;
        @(posedge clk); #1;
        start = 1'b0;
        t = ptr;
        bit_valid = 1'b1;
        for (int k = 0; k < 50 && (ptr - t) < 10; k++) begin
            bit_in = b[(ptr - t) % 64];
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        if ((ptr - t) != 10) fail_now("reset_setup");
        reset = 1'b0;
        #2;
        chk("mid_rst_start_ready", int'(start_ready), 1);
        chk("mid_rst_bit_ready", int'(bit_ready), 0);
        chk("mid_rst_run_valid", int'(run_valid), 0);
        chk("mid_rst_run_len", int'(run_len), 0);
        chk("mid_rst_run_index", int'(run_index), 0);
        chk("mid_rst_j_out", int'(j_out), 0);
        chk("mid_rst_err", int'(err), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        m_idx = 0;
        run_one(10, 64'b011, 1);
        chk("t7_len", e_len, 2); chk("t7_intr", e_intr, 1); chk("t7_idx", e_idx, 1);

        // Randomized runs.
        for (int r = 0; r < 80; r++) begin
            int rem;
            if ($urandom % 10 == 0) do_clear();
            rem = ($urandom % 2) ? $urandom_range(0, 1023) : $urandom_range(0, 24);
            for (int k = 0; k < 64; k++) b[k] = ($urandom % 3) != 0;
            run_one(rem, b, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/run_dec.md
Name: run_dec

Overview:
- JPEG-LS run-mode decoder. It is the decoder-side counterpart of the encoder's run-count/run-index coder.
- It consumes the serial run-code bitstream one bit per handshake and rebuilds the run length. It tracks RUNindex across runs and reports whether the run ended by interruption or by end-of-line.
- It sits between the bitstream reader and the pixel reconstruction stage. The reconstruction stage replicates Ra run_len times and then decodes the interruption sample.

Parameters:
- RUN_W, 10, width of the run-length and remaining-samples fields (line width up to 2^RUN_W-1).
- IDX_MAX, 31, maximum RUNindex value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- clear  in  1  synchronous scan-start; sets RUNindex=0 and aborts any run in progress
- start  in  1  begin decoding one run; accepted only when start_ready=1
- start_ready  out  1  block is in IDLE
- remaining  in  RUN_W  samples left in the line including the current one; sampled when start is accepted
- bit_in  in  1  next stream bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  block will consume bit_in this cycle
- run_valid  out  1  result available
- run_ready  in  1  result consumed
- run_len  out  RUN_W  decoded run length
- run_intr  out  1  1 = run ended by a '0' bit (an interruption sample follows); 0 = end-of-line
- j_out  out  4  J[RUNindex] used for the interruption (the value before the decrement); 0 when run_intr=0
- run_index  out  5  current RUNindex
- err  out  1  remainder overflow (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, RUNindex=0, accumulator=0, left=0. All outputs are 0 except start_ready=1.
- J table, indexed 0..31: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15. Run granule rg = 2^J.
- Bit handshake: a bit is consumed only when bit_valid & bit_ready. bit_ready is high only in UNARY and REM.
- IDLE:
  - On start: acc=0, left=remaining.
  - If remaining=0, go to DONE with run_len=0, run_intr=0; no bits are consumed.
  - Otherwise go to UNARY.
- UNARY, on a consumed '1':
  - If rg <= left: acc+=rg, left-=rg, RUNindex++ (saturate at IDX_MAX). If the new left=0, go to DONE with run_intr=0.
  - If rg > left: acc+=left, left=0, RUNindex unchanged, go to DONE with run_intr=0.
- UNARY, on a consumed '0':
  - Latch j_out=J[RUNindex].
  - If J=0, go directly to DONE with run_intr=1.
  - Otherwise go to REM with bitcnt=J.
- REM: shift in exactly J bits, MSB first, into a 16-bit remainder. After the last bit: acc+=remainder, run_intr=1, go to DONE.
- Interruption index update: when run_intr=1 is reported, RUNindex decrements by 1 if it is >0. The update takes effect in the cycle DONE is entered, so run_index shows the post-decrement value while run_valid is high.
- DONE:
  - run_valid=1; run_len, run_intr and j_out are held stable until run_ready.
  - On run_ready, go to IDLE; start_ready rises on the next cycle.
  - start_ready=0 and bit_ready=0 throughout DONE.
- Latency:
  - One cycle per consumed bit.
  - run_valid rises the cycle after the terminating bit is consumed.
  - An immediate '0' with J=0 gives run_valid 1 cycle after the bit.
- Arithmetic: acc and left are RUN_W wide. Truncation of the 16-bit remainder to RUN_W is legal only for conforming streams.
- clear has priority over every other event in the same cycle. It forces IDLE and RUNindex=0, drops run_valid, and any bit offered that cycle is not consumed.
- A start arriving while the block is not in IDLE is ignored; the source must hold it.
- A reset asserted mid-run, in any state, returns everything to the reset values immediately.

Optional Feature:
- Macro: RUN_DEC_ERR_CHK_EN.
- Defined:
  - In REM, a completed remainder >= left sets err=1 together with run_valid.
  - run_len then saturates to acc+left-1.
  - err clears when the result is accepted (run_ready) or on clear.
- Undefined: err is tied to 0 and the remainder is added without any check.

Decomposition:
- Package run_pkg:
  - State enum IDLE/UNARY/REM/DONE.
  - IDX_W=5, J_W=4.
  - J-table constant array.
  - Function rg_of(idx) returning 2^J.
- Sub-module run_j_rom: combinational idx->J lookup, shared with the encoder side.
- All state sits in run_dec.

Test Plan:
- clear; start remaining=10; bits 1,1,1,1,0,1 -> run_len=5, run_intr=1, j_out=1, run_index=3, exactly 6 bits consumed.
- RUNindex=0, start remaining=3; bits 1,1,1 -> run_len=3, run_intr=0, run_index=3, bit_ready low after the 3rd bit, a 4th offered bit is not consumed.
- RUNindex=4 (rg=2), start remaining=1; bit 1 -> run_len=1, run_intr=0, run_index stays 4.
- RUNindex=0, bit 0 -> run_len=0, run_intr=1, j_out=0, run_index stays 0, run_valid 1 cycle after the bit.
- Hold run_ready=0 for 3 cycles in DONE -> run_len/run_intr/j_out stable; bit_ready=0 and start_ready=0 throughout.
- Assert reset in REM after 1 of 2 remainder bits -> all outputs at reset values, run_index=0; next run decodes correctly from index 0. With RUN_DEC_ERR_CHK_EN: left=2, J=2, remainder 3 -> err=1.
